mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle successor to the single-cycle instruction decoder: one FSM sequences fetch, decode, execute, memory and writeback over several clocks.
- Decodes the same instruction set: R-type, jr, syscall, beq, bne, j, jal, lw, sw, lui, ori, addi.
- Memory accesses use a req/ready handshake with a parametrised timeout.
- Sits between the shared instruction/data memory port, the IR/PC registers and the ALU/register-file datapath.

Parameters:
- MAX_WAIT, 15: cycles to wait for mem_ready before entering FAULT; legal range 1..255.
- WAIT_W, 8: width of the internal wait counter; must hold MAX_WAIT.
- RESET_RUN, 0: 1 = leave IDLE for FETCH on the first cycle after reset without waiting for run.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- run  in  1  start/continue request; sampled in IDLE.
- instr  in  32  current IR contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_zero  in  1  ALU zero flag, valid in BRANCH.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write request; qualifies mem_req.
- i_or_d  out  1  0 = PC address, 1 = ALU result address.
- ir_write  out  1  latch memory data into IR.
- pc_write  out  1  load PC from the pc_src mux.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr).
- alu_src_b  out  2  00 rt, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
- alu_op  out  2  00 add, 01 subtract (branch compare), 10 use func.
- func  out  6  ALU function code.
- reg_write  out  1  register-file write strobe.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  1  writeback data from memory.
- lui  out  1  writeback selects {imm, 16'h0}.
- halted  out  1  syscall reached.
- fault  out  1  memory timeout or illegal opcode.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (async): state=IDLE, wait counter=0. Every output is 0 except state=0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, JUMP=7, HALT=8, FAULT=9.
- All outputs are Moore functions of state plus instr. No output depends combinationally on mem_ready, except pc_write/ir_write in FETCH and reg_write for lw in MEM.
- IDLE: go to FETCH when run=1 (or unconditionally if RESET_RUN=1).
- FETCH: mem_req=1, i_or_d=0, alu_src_b=01, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise increment the wait counter.
- DECODE: alu_src_b=11 to precompute the branch target. Next state by opcode:
  - instr==32'h0000000C → HALT.
  - opcode 000000 with func 001000 (jr) → JUMP.
  - Other opcode 000000 → EXEC.
  - beq (000100), bne (000101) → BRANCH.
  - j (000010), jal (000011) → JUMP.
  - lw (100011), sw (101011), addi (001000), ori (001101) → EXEC.
  - lui (001111) → WB.
  - Any other opcode → FAULT.
- EXEC:
  - R-type: alu_op=10, func=instr[5:0].
  - addi: func=100000.
  - ori: func=100101.
  - lw/sw: alu_op=00, alu_src_b=10.
  - Next: lw/sw → MEM; others → WB.
- MEM: mem_req=1, i_or_d=1, mem_we=1 for sw.
  - On mem_ready: lw asserts reg_write=1, reg_dst=00, mem_to_reg=1 in the same cycle; both lw and sw go to FETCH.
  - Otherwise increment the wait counter.
- WB: reg_write=1, then go to FETCH.
  - R-type: reg_dst=01.
  - addi/ori: reg_dst=00.
  - lui: lui=1, reg_dst=00.
- BRANCH: alu_op=01, pc_src=01. pc_write=1 when (beq && alu_zero) or (bne && !alu_zero). Then go to FETCH.
- JUMP: pc_write=1, then go to FETCH.
  - j/jal: pc_src=10.
  - jr: pc_src=11.
  - jal: reg_write=1, reg_dst=10.
- Wait counter: clears on every state change. On reaching MAX_WAIT with mem_ready still 0, go to FAULT. mem_ready arriving on the MAX_WAIT cycle itself completes normally.
- HALT: halted=1, sticky. FAULT: fault=1, sticky. Both exit only on reset; run is ignored.
- Reset asserted mid-access drops mem_req in the same cycle (async).

Optional Feature:
- Macro: MC_CONTROL_PERF_EN.
- When defined, add outputs retired[31:0] and stall_cycles[31:0]:
  - retired increments when a non-fault instruction completes: the cycle leaving WB, BRANCH or JUMP, MEM with mem_ready, or entering HALT.
  - stall_cycles increments on each FETCH/MEM cycle with mem_req=1 and mem_ready=0.
  - Both wrap at 2^32 and clear on reset.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- addi $1,$0,5 (0x20010005), mem_ready always 1 → states 1,2,3,5,1; WB shows reg_write=1, reg_dst=00; 4 cycles per instruction.
- lw 0x8C220004 with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles, then reg_write=1 and mem_to_reg=1 in the ready cycle, then FETCH.
- beq with alu_zero=1 → pc_write=1, pc_src=01. bne with alu_zero=1 → pc_write=0. Both return to FETCH.
- jal 0x0C000010 → JUMP with pc_src=10, reg_write=1, reg_dst=10. jr $31 (0x03E00008) → pc_src=11, reg_write=0.
- mem_ready held 0 in FETCH, MAX_WAIT=15 → FAULT after 15 wait cycles, fault=1 sticky; opcode 111111 → FAULT directly from DECODE.
- syscall 0x0000000C → HALT, halted=1. Async reset mid-MEM → all outputs 0 immediately; with PERF_EN, retired is correct after a 5-instruction program.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-subset control FSM.
// Sequences FETCH -> DECODE -> EXEC/BRANCH/JUMP -> MEM/WB over several clocks,
// with a req/ready memory handshake guarded by a MAX_WAIT timeout.
// Optional build macro MC_CONTROL_PERF_EN adds retired / stall_cycles counters.
module mc_control #(
   parameter int MAX_WAIT  = 15,  // cycles to wait for mem_ready, 1..255
   parameter int WAIT_W    = 8,   // wait counter width, must hold MAX_WAIT
   parameter int RESET_RUN = 0    // 1 = leave IDLE right after reset
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        alu_zero,
   output logic        mem_req,
   output logic        mem_we,
   output logic        i_or_d,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [5:0]  func,
   output logic        reg_write,
   output logic [1:0]  reg_dst,
   output logic        mem_to_reg,
   output logic        lui,
   output logic        halted,
   output logic        fault,
   output logic [3:0]  state
`ifdef MC_CONTROL_PERF_EN
   ,
   output logic [31:0] retired,
   output logic [31:0] stall_cycles
`endif
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEM    = 4'd4,
      S_WB     = 4'd5,
      S_BRANCH = 4'd6,
      S_JUMP   = 4'd7,
      S_HALT   = 4'd8,
      S_FAULT  = 4'd9
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [31:0] SYSCALL = 32'h0000_000C;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   // Instruction field decode, shared by every state that looks at the IR.
   logic [5:0] opcode;
   logic       is_rtype, is_jr, is_sys, is_beq, is_bne, is_j, is_jal;
   logic       is_lw, is_sw, is_addi, is_ori, is_lui, is_mem_op;
   logic       wait_expired;

   // Opcode/function classification of the current IR.
   always_comb begin
      opcode    = instr[31:26];
      is_sys    = (instr == SYSCALL);
      is_jr     = (opcode == OP_RTYPE) && (instr[5:0] == FN_JR);
      is_rtype  = (opcode == OP_RTYPE) && !is_jr;
      is_beq    = (opcode == OP_BEQ);
      is_bne    = (opcode == OP_BNE);
      is_j      = (opcode == OP_J);
      is_jal    = (opcode == OP_JAL);
      is_lw     = (opcode == OP_LW);
      is_sw     = (opcode == OP_SW);
      is_addi   = (opcode == OP_ADDI);
      is_ori    = (opcode == OP_ORI);
      is_lui    = (opcode == OP_LUI);
      is_mem_op = is_lw || is_sw;
      // The counter reads MAX_WAIT after MAX_WAIT stalled cycles; that cycle
      // is still allowed to complete if mem_ready finally shows up.
      wait_expired = (wait_q == WAIT_LIMIT);
   end

   // State and wait-counter registers; reset forces IDLE immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state and Moore outputs (plus the few mem_ready-qualified strobes).
   always_comb begin
      state_d    = state_q;
      wait_d     = '0;       // any state change clears the counter
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      func       = 6'b000000;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 1'b0;
      lui        = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run || (RESET_RUN != 0)) state_d = S_FETCH;
         end

         S_FETCH: begin
            // PC drives the address; ALU forms PC+4 alongside the read.
            mem_req   = 1'b1;
            i_or_d    = 1'b0;
            alu_src_b = 2'b01;
            alu_op    = 2'b00;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               pc_src   = 2'b00;
               state_d  = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end

         S_DECODE: begin
            // Branch target is precomputed here while the opcode is sorted.
            alu_src_b = 2'b11;
            if (is_sys)                                  state_d = S_HALT;
            else if (is_jr)                              state_d = S_JUMP;
            else if (is_rtype)                           state_d = S_EXEC;
            else if (is_beq || is_bne)                   state_d = S_BRANCH;
            else if (is_j || is_jal)                     state_d = S_JUMP;
            else if (is_mem_op || is_addi || is_ori)     state_d = S_EXEC;
            else if (is_lui)                             state_d = S_WB;
            else                                         state_d = S_FAULT;
         end

         S_EXEC: begin
            if (is_rtype) begin
               alu_op    = 2'b10;
               func      = instr[5:0];
               alu_src_b = 2'b00;
            end else if (is_addi) begin
               alu_op    = 2'b10;
               func      = FN_ADD;
               alu_src_b = 2'b10;
            end else if (is_ori) begin
               alu_op    = 2'b10;
               func      = FN_OR;
               alu_src_b = 2'b10;
            end else begin
               // lw/sw: base + sign-extended offset
               alu_op    = 2'b00;
               alu_src_b = 2'b10;
            end
            state_d = is_mem_op ? S_MEM : S_WB;
         end

         S_MEM: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            mem_we  = is_sw;
            if (mem_ready) begin
               // lw writes the returned word straight into rt this cycle.
               if (is_lw) begin
                  reg_write  = 1'b1;
                  reg_dst    = 2'b00;
                  mem_to_reg = 1'b1;
               end
               state_d = S_FETCH;
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end

         S_WB: begin
            reg_write = 1'b1;
            reg_dst   = is_rtype ? 2'b01 : 2'b00;
            lui       = is_lui;
            state_d   = S_FETCH;
         end

         S_BRANCH: begin
            alu_op   = 2'b01;
            pc_src   = 2'b01;
            pc_write = (is_beq && alu_zero) || (is_bne && !alu_zero);
            state_d  = S_FETCH;
         end

         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = is_jr ? 2'b11 : 2'b10;
            if (is_jal) begin
               reg_write = 1'b1;
               reg_dst   = 2'b10;
            end
            state_d = S_FETCH;
         end

         S_HALT: begin
            halted = 1'b1;
         end

         S_FAULT: begin
            fault = 1'b1;
         end

         default: begin
            // Unused encodings are treated as a machine fault.
            state_d = S_FAULT;
         end
      endcase
   end

   assign state = state_q;

`ifdef MC_CONTROL_PERF_EN
   logic [31:0] retired_q, retired_d;
   logic [31:0] stall_q, stall_d;
   logic        retire_evt, stall_evt;

   // Retire/stall event detection and counter increments (wrap naturally).
   always_comb begin
      retire_evt = (state_q == S_WB) || (state_q == S_BRANCH) ||
                   (state_q == S_JUMP) ||
                   ((state_q == S_MEM) && mem_ready) ||
                   ((state_q == S_DECODE) && (state_d == S_HALT));
      stall_evt  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
      retired_d  = retired_q;
      stall_d    = stall_q;
      if (retire_evt) retired_d = retired_q + 32'd1;
      if (stall_evt)  stall_d   = stall_q + 32'd1;
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         retired_q <= retired_d;
         stall_q   <= stall_d;
      end
   end

   assign retired      = retired_q;
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Table-driven bench for mc_control: per-cycle {inputs, expected outputs}
// records are driven after the rising edge and checked at the falling edge
// through a scoreboard queue; a hand sequence covers async reset mid-MEM.
module tb_mc_control;

   logic        clk = 1'b0, reset = 1'b1, run = 1'b0;
   logic        mem_ready = 1'b0, alu_zero = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        mem_req, mem_we, i_or_d, ir_write, pc_write;
   logic [1:0]  pc_src, alu_src_b, alu_op, reg_dst;
   logic [5:0]  func;
   logic        reg_write, mem_to_reg, lui, halted, fault;
   logic [3:0]  state;
`ifdef MC_CONTROL_PERF_EN
   logic [31:0] retired, stall_cycles;
`endif

   always #5 clk = ~clk;

   mc_control #(.MAX_WAIT(15), .WAIT_W(8), .RESET_RUN(0)) dut (
      .clk(clk), .reset(reset), .run(run), .instr(instr),
      .mem_ready(mem_ready), .alu_zero(alu_zero),
      .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .func(func),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .lui(lui), .halted(halted), .fault(fault), .state(state)
`ifdef MC_CONTROL_PERF_EN
      , .retired(retired), .stall_cycles(stall_cycles)
`endif
   );

   typedef struct packed {
      logic [3:0] st;
      logic       req, we, iord, irw, pcw;
      logic [1:0] pcs, asb, aop;
      logic [5:0] fn;
      logic       rw;
      logic [1:0] rd;
      logic       m2r, lu, h, f;
   } outs_t;

   typedef struct {
      logic        rst, run, rdy, az;
      logic [31:0] ins;
      outs_t       e;
   } vec_t;

   typedef struct {
      int    idx;
      outs_t e;
   } sb_t;

   outs_t act;
   assign act = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                 alu_src_b, alu_op, func, reg_write, reg_dst, mem_to_reg,
                 lui, halted, fault};

   vec_t vecs[$];
   sb_t  sb[$];
   int   checks = 0, failures = 0;

   localparam logic [31:0] I_ADDI = 32'h20010005;
   localparam logic [31:0] I_ADD  = 32'h00221820;
   localparam logic [31:0] I_ORI  = 32'h34420001;
   localparam logic [31:0] I_LUI  = 32'h3C011234;
   localparam logic [31:0] I_SW   = 32'hAC220004;
   localparam logic [31:0] I_LW   = 32'h8C220004;
   localparam logic [31:0] I_BEQ  = 32'h10220003;
   localparam logic [31:0] I_BNE  = 32'h14220003;
   localparam logic [31:0] I_JAL  = 32'h0C000010;
   localparam logic [31:0] I_J    = 32'h08000010;
   localparam logic [31:0] I_JR   = 32'h03E00008;
   localparam logic [31:0] I_SYS  = 32'h0000000C;
   localparam logic [31:0] I_BAD  = 32'hFC000000;

   function automatic outs_t E(input logic [3:0] st, input logic req, we, iord, irw, pcw,
                               input logic [1:0] pcs, asb, aop, input logic [5:0] fn,
                               input logic rw, input logic [1:0] rd,
                               input logic m2r, lu, h, f);
      outs_t o;
      o = {st, req, we, iord, irw, pcw, pcs, asb, aop, fn, rw, rd, m2r, lu, h, f};
      return o;
   endfunction

   function automatic outs_t e_zero(input logic [3:0] st);
      return E(st, 0,0,0,0,0, 2'd0,2'd0,2'd0, 6'd0, 0,2'd0, 0,0,0,0);
   endfunction

   function automatic outs_t e_fetch(input logic rdy);
      return E(4'd1, 1,0,0,rdy,rdy, 2'd0,2'd1,2'd0, 6'd0, 0,2'd0, 0,0,0,0);
   endfunction

   function automatic outs_t e_dec();
      return E(4'd2, 0,0,0,0,0, 2'd0,2'd3,2'd0, 6'd0, 0,2'd0, 0,0,0,0);
   endfunction

   task automatic av(input logic rst, r, input logic [31:0] ins,
                     input logic rdy, az, input outs_t e);
      vec_t v;
      v.rst = rst; v.run = r; v.ins = ins; v.rdy = rdy; v.az = az; v.e = e;
      vecs.push_back(v);
   endtask

   // fetch (ready at once) + decode for one instruction
   task automatic fd(input logic [31:0] ins);
      av(0, 0, ins, 1, 0, e_fetch(1));
      av(0, 0, ins, 1, 0, e_dec());
   endtask

   task automatic chk(input string name, input logic [31:0] got, exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic run_range(input int a, input int b);
      for (int i = a; i < b; i++) begin
         sb_t s;
         @(posedge clk);
         #1;
         reset     = vecs[i].rst;
         run       = vecs[i].run;
         instr     = vecs[i].ins;
         mem_ready = vecs[i].rdy;
         alu_zero  = vecs[i].az;
         s.idx = i; s.e = vecs[i].e;
         sb.push_back(s);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", sb.size());
      end
   endtask

   // Scoreboard: compare each pushed expectation at the following falling edge.
   always @(negedge clk) begin : mon
      sb_t s;
      if (sb.size() > 0) begin
         s = sb.pop_front();
         checks++;
         if (act !== s.e) begin
            failures++;
            $display("FAIL vec%0d got=%h exp=%h", s.idx, act, s.e);
         end
      end
   end

   initial begin : main
      int m_a, m_b, m_c;

      // ---- segment A: reset, idle, 5-instruction program ending in syscall
      av(1, 0, 0, 0, 0, e_zero(0));
      av(0, 0, 0, 0, 0, e_zero(0));                     // idle holds without run
      av(0, 0, 0, 0, 0, e_zero(0));
      av(0, 1, 0, 0, 0, e_zero(0));
      av(0, 0, I_ADDI, 0, 0, e_fetch(0));               // 2 stalled fetch cycles
      av(0, 0, I_ADDI, 0, 0, e_fetch(0));
      fd(I_ADDI);
      av(0, 0, I_ADDI, 1, 0, E(3, 0,0,0,0,0, 0,2,2, 6'h20, 0,0, 0,0,0,0));
      av(0, 0, I_ADDI, 1, 0, E(5, 0,0,0,0,0, 0,0,0, 6'h00, 1,0, 0,0,0,0));
      fd(I_ADD);
      av(0, 0, I_ADD, 1, 0, E(3, 0,0,0,0,0, 0,0,2, 6'h20, 0,0, 0,0,0,0));
      av(0, 0, I_ADD, 1, 0, E(5, 0,0,0,0,0, 0,0,0, 6'h00, 1,1, 0,0,0,0));
      fd(I_LUI);
      av(0, 0, I_LUI, 1, 0, E(5, 0,0,0,0,0, 0,0,0, 6'h00, 1,0, 0,1,0,0));
      fd(I_BEQ);
      av(0, 0, I_BEQ, 1, 0, E(6, 0,0,0,0,0, 1,0,1, 6'h00, 0,0, 0,0,0,0));
      fd(I_SYS);
      av(0, 1, I_SYS, 1, 0, E(8, 0,0,0,0,0, 0,0,0, 6'h00, 0,0, 0,0,1,0));
      av(0, 1, I_SYS, 1, 0, E(8, 0,0,0,0,0, 0,0,0, 6'h00, 0,0, 0,0,1,0));
      m_a = vecs.size();

      // ---- segment B: remaining instruction classes, illegal opcode
      av(1, 0, 0, 0, 0, e_zero(0));
      av(0, 1, 0, 0, 0, e_zero(0));
      fd(I_ORI);
      av(0, 0, I_ORI, 1, 0, E(3, 0,0,0,0,0, 0,2,2, 6'h25, 0,0, 0,0,0,0));
      av(0, 0, I_ORI, 1, 0, E(5, 0,0,0,0,0, 0,0,0, 6'h00, 1,0, 0,0,0,0));
      fd(I_SW);
      av(0, 0, I_SW, 1, 0, E(3, 0,0,0,0,0, 0,2,0, 6'h00, 0,0, 0,0,0,0));
      av(0, 0, I_SW, 1, 0, E(4, 1,1,1,0,0, 0,0,0, 6'h00, 0,0, 0,0,0,0));
      fd(I_LW);
      av(0, 0, I_LW, 1, 0, E(3, 0,0,0,0,0, 0,2,0, 6'h00, 0,0, 0,0,0,0));
      for (int k = 0; k < 3; k++)
         av(0, 0, I_LW, 0, 0, E(4, 1,0,1,0,0, 0,0,0, 6'h00, 0,0, 0,0,0,0));
      av(0, 0, I_LW, 1, 0, E(4, 1,0,1,0,0, 0,0,0, 6'h00, 1,0, 1,0,0,0));
      fd(I_BEQ);
      av(0, 0, I_BEQ, 1, 1, E(6, 0,0,0,0,1, 1,0,1, 6'h00, 0,0, 0,0,0,0));
      fd(I_BNE);
      av(0, 0, I_BNE, 1, 1, E(6, 0,0,0,0,0, 1,0,1, 6'h00, 0,0, 0,0,0,0));
      fd(I_BNE);
      av(0, 0, I_BNE, 1, 0, E(6, 0,0,0,0,1, 1,0,1, 6'h00, 0,0, 0,0,0,0));
      fd(I_JAL);
      av(0, 0, I_JAL, 1, 0, E(7, 0,0,0,0,1, 2,0,0, 6'h00, 1,2, 0,0,0,0));
      fd(I_J);
      av(0, 0, I_J, 1, 0, E(7, 0,0,0,0,1, 2,0,0, 6'h00, 0,0, 0,0,0,0));
      fd(I_JR);
      av(0, 0, I_JR, 1, 0, E(7, 0,0,0,0,1, 3,0,0, 6'h00, 0,0, 0,0,0,0));
      fd(I_BAD);
      av(0, 1, I_BAD, 1, 0, E(9, 0,0,0,0,0, 0,0,0, 6'h00, 0,0, 0,0,0,1));
      av(0, 1, I_BAD, 1, 0, E(9, 0,0,0,0,0, 0,0,0, 6'h00, 0,0, 0,0,0,1));
      m_b = vecs.size();

      // ---- segment C: ready on the last allowed cycle, then fetch timeout
      av(1, 0, 0, 0, 0, e_zero(0));
      av(0, 1, 0, 0, 0, e_zero(0));
      for (int k = 0; k < 15; k++) av(0, 0, I_ADDI, 0, 0, e_fetch(0));
      av(0, 0, I_ADDI, 1, 0, e_fetch(1));
      av(0, 0, I_ADDI, 1, 0, e_dec());
      av(0, 0, I_ADDI, 1, 0, E(3, 0,0,0,0,0, 0,2,2, 6'h20, 0,0, 0,0,0,0));
      av(0, 0, I_ADDI, 1, 0, E(5, 0,0,0,0,0, 0,0,0, 6'h00, 1,0, 0,0,0,0));
      for (int k = 0; k < 16; k++) av(0, 0, I_ADDI, 0, 0, e_fetch(0));
      av(0, 1, I_ADDI, 1, 0, E(9, 0,0,0,0,0, 0,0,0, 6'h00, 0,0, 0,0,0,1));
      av(0, 1, I_ADDI, 1, 0, E(9, 0,0,0,0,0, 0,0,0, 6'h00, 0,0, 0,0,0,1));
      m_c = vecs.size();

      // ---- segment D: into a stalled lw MEM access
      av(1, 0, 0, 0, 0, e_zero(0));
      av(0, 1, 0, 0, 0, e_zero(0));
      fd(I_LW);
      av(0, 0, I_LW, 1, 0, E(3, 0,0,0,0,0, 0,2,0, 6'h00, 0,0, 0,0,0,0));
      av(0, 0, I_LW, 0, 0, E(4, 1,0,1,0,0, 0,0,0, 6'h00, 0,0, 0,0,0,0));

      run_range(0, m_a);
      drain();
`ifdef MC_CONTROL_PERF_EN
      chk("retired_prog", retired, 32'd5);
      chk("stall_prog", stall_cycles, 32'd2);
`endif
      run_range(m_a, m_b);
      drain();
      run_range(m_b, m_c);
      drain();
      run_range(m_c, vecs.size());
      drain();

      // async reset in the middle of a stalled MEM access
      @(posedge clk);
      #2;
      chk("mem_stall_state", {28'd0, state}, 32'd4);
      chk("mem_stall_req", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      #1;
      chk("async_rst_outs", {4'd0, act}, 32'd0);
`ifdef MC_CONTROL_PERF_EN
      chk("async_rst_retired", retired, 32'd0);
`endif
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
